// File: rtl/au_pkg.sv
// Shared types and elaboration helpers for the arithmetic unit serial blocks.
// Latency: none (package only). Backpressure: not applicable.
// Holds the control FSM state encoding and the digit-count sizing functions.
package au_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int ncyc);
        return (ncyc > 1) ? $clog2(ncyc) : 1;
    endfunction

endpackage

// File: rtl/au_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice with a valid-lane limit.
// Latency: zero cycles (pure combinational). Backpressure: none, owner sequences it.
// Lanes at or above nvalid produce zero sum and pass the carry straight through.
module au_addsub_digit
    import au_pkg::*;
#(
    parameter int DIGIT = 4,
    parameter int NVW   = $clog2(DIGIT + 1)
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic [NVW-1:0]   nvalid,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic c;

    always_comb begin
        c     = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (NVW'(i) < nvalid) begin
                sum[i] = a[i] ^ b[i] ^ c;
                // Carry entering the top valid lane feeds the overflow flag.
                if (NVW'(i + 1) == nvalid) begin
                    c_msb = c;
                end
                c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        cout = c;
    end

endmodule

// File: rtl/au_addsub_serial.sv
// Digit-serial 2's complement adder-subtractor with carry-in and overflow flag.
// Latency: NCYC = ceil(WIDTH/DIGIT) cycles from accept to out_valid; one bubble after retire.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module au_addsub_serial
    import au_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             add_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             v,
    output logic             busy
);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_param
        $fatal(1, "au_addsub_serial: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
    end

    localparam int NCYC = ceil_div(WIDTH, DIGIT);
    localparam int KW   = cnt_width(NCYC);
    localparam int LAST = WIDTH - (NCYC - 1) * DIGIT;
    localparam int NVW  = $clog2(DIGIT + 1);
    localparam logic [KW-1:0]    K_LAST = KW'(NCYC - 1);
    localparam logic [WIDTH-1:0] DMASK  = WIDTH'({DIGIT{1'b1}});

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  s_q;
    logic              v_q;

    logic              accept;
    logic              last_dig;
    logic [31:0]       sh;
    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic [DIGIT-1:0]  sum_dig;
    logic              cout_dig;
    logic              cmsb_dig;
    logic [NVW-1:0]    nvalid;
    logic [WIDTH-1:0]  s_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign s         = s_q;
    assign v         = v_q;

    assign accept   = in_valid & in_ready;
    assign last_dig = (k == K_LAST);
    assign sh       = 32'(k) * 32'(DIGIT);
    assign nvalid   = last_dig ? NVW'(LAST) : NVW'(DIGIT);

    // Right shift zero-fills the lanes of a partial final digit.
    assign a_dig = DIGIT'(a_q >> sh);
    assign b_dig = DIGIT'(b_q >> sh);
    // Truncation to WIDTH keeps unused top lanes of the last digit out of s.
    assign s_nxt = (s_q & ~(DMASK << sh)) | (WIDTH'(sum_dig) << sh);

    au_addsub_digit #(
        .DIGIT (DIGIT),
        .NVW   (NVW)
    ) u_digit (
        .a      (a_dig),
        .b      (b_dig),
        .cin    (carry),
        .nvalid (nvalid),
        .sum    (sum_dig),
        .cout   (cout_dig),
        .c_msb  (cmsb_dig)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last_dig)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            k     <= '0;
            s_q   <= '0;
            v_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtraction as a + ~b + ~ci equals a - b - ci.
                        a_q   <= a;
                        b_q   <= add_sub ? ~b : b;
                        carry <= add_sub ? ~ci : ci;
                        k     <= '0;
                    end
                end
                CALC: begin
                    s_q   <= s_nxt;
                    carry <= cout_dig;
                    k     <= k + 1'b1;
                    if (last_dig) begin
                        v_q <= cmsb_dig ^ cout_dig;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
